// File: rtl/tdc_measure_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tdc_ctrl_pkg
// Description : Shared widths, FSM state encoding, result record and a
//               6-bit ones-count helper for the TDC measurement sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_ctrl_pkg;

  localparam int c_SEQ_W    = 36;
  localparam int c_FINE_W   = 6;
  localparam int c_COARSE_W = 16;
  localparam int c_GROUP_W  = 6;
  localparam int c_GROUPS   = c_SEQ_W / c_GROUP_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESULT  = 2'd3
  } tdc_state_t;

  typedef struct packed {
    logic                  timeout;
    logic [c_COARSE_W-1:0] coarse;
    logic [c_FINE_W-1:0]   fine;
  } tdc_result_t;

  function automatic logic [2:0] ones6(input logic [c_GROUP_W-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < c_GROUP_W; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_measure_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : tdc_measure_sequencer_if
// Description : Control, snapshot and valid/ready result signals of the TDC
//               sequencer. TDC_FINE_OFFSET_EN adds i_Fine_Offset.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_measure_sequencer_if #(
  parameter int COARSE_W = tdc_ctrl_pkg::c_COARSE_W
) ();

  logic                              i_Arm;
  logic                              i_Hit;
  logic [tdc_ctrl_pkg::c_SEQ_W-1:0]  i_Sequence;
  logic                              i_Ready;
`ifdef TDC_FINE_OFFSET_EN
  logic [tdc_ctrl_pkg::c_FINE_W-1:0] i_Fine_Offset;
`endif
  logic                              o_Busy;
  logic                              o_Valid;
  logic [COARSE_W-1:0]               o_Coarse;
  logic [tdc_ctrl_pkg::c_FINE_W-1:0] o_Fine;
  logic                              o_Timeout;

`ifdef TDC_FINE_OFFSET_EN
  modport master (
    output i_Arm, i_Hit, i_Sequence, i_Ready, i_Fine_Offset,
    input  o_Busy, o_Valid, o_Coarse, o_Fine, o_Timeout
  );
  modport slave (
    input  i_Arm, i_Hit, i_Sequence, i_Ready, i_Fine_Offset,
    output o_Busy, o_Valid, o_Coarse, o_Fine, o_Timeout
  );
`else
  modport master (
    output i_Arm, i_Hit, i_Sequence, i_Ready,
    input  o_Busy, o_Valid, o_Coarse, o_Fine, o_Timeout
  );
  modport slave (
    input  i_Arm, i_Hit, i_Sequence, i_Ready,
    output o_Busy, o_Valid, o_Coarse, o_Fine, o_Timeout
  );
`endif

endinterface
`default_nettype wire

// File: rtl/tdc_thermo_popcount.sv
`default_nettype none
// ============================================================================
// Module      : tdc_thermo_popcount
// Description : Exact 36->6 ones counter; six 6-bit group counts summed in a
//               tree, one output register loaded when i_En is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_thermo_popcount
  import tdc_ctrl_pkg::*;
(
  input  wire                 i_Clk,
  input  wire                 i_Reset,
  input  wire                 i_En,
  input  wire [c_SEQ_W-1:0]   i_Code,
  output logic [c_FINE_W-1:0] o_Count
);

  logic [2:0]          w_Grp  [c_GROUPS];
  logic [3:0]          w_Pair [c_GROUPS/2];
  logic [c_FINE_W-1:0] w_Total;
  logic [c_FINE_W-1:0] r_Count;

  for (genvar g = 0; g < c_GROUPS; g++) begin : g_grp
    assign w_Grp[g] = ones6(i_Code[g*c_GROUP_W +: c_GROUP_W]);
  end

  for (genvar p = 0; p < c_GROUPS/2; p++) begin : g_pair
    assign w_Pair[p] = {1'b0, w_Grp[2*p]} + {1'b0, w_Grp[2*p+1]};
  end

  assign w_Total = c_FINE_W'(w_Pair[0]) + c_FINE_W'(w_Pair[1]) + c_FINE_W'(w_Pair[2]);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Count <= '0;
    end else if (i_En) begin
      r_Count <= w_Total;
    end
  end

  assign o_Count = r_Count;

endmodule
`default_nettype wire

// File: rtl/tdc_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_measure_sequencer
// Description : Arm -> wait for hit -> snapshot delay line; reports coarse
//               cycle index, fine ones count and timeout on a valid/ready port.
//               Optional macro TDC_FINE_OFFSET_EN: saturating fine offset.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_measure_sequencer
  import tdc_ctrl_pkg::*;
#(
  parameter int COARSE_W    = c_COARSE_W,
  parameter int TIMEOUT_CYC = 65536
) (
  input wire                       i_Clk,
  input wire                       i_Reset,
  tdc_measure_sequencer_if.slave   io_Bus
);

  localparam logic [COARSE_W-1:0] c_LAST = COARSE_W'(TIMEOUT_CYC - 1);

  tdc_state_t          r_State;
  logic [COARSE_W-1:0] r_Count;
  logic                r_Busy;
  logic                r_Valid;
  logic [COARSE_W-1:0] r_Coarse;
  logic [c_FINE_W-1:0] r_Fine;
  logic                r_Timeout;

  logic                w_Capture;
  logic [c_FINE_W-1:0] w_Pop;
  logic [c_FINE_W-1:0] w_Fine;

  // The snapshot is reduced to its ones count in the hit cycle, so only six
  // bits are held across CAPTURE instead of the full 36-bit code.
  assign w_Capture = (r_State == S_ARMED) && io_Bus.i_Hit;

  tdc_thermo_popcount u_popcount (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_En    (w_Capture),
    .i_Code  (io_Bus.i_Sequence),
    .o_Count (w_Pop)
  );

`ifdef TDC_FINE_OFFSET_EN
  assign w_Fine = (w_Pop > io_Bus.i_Fine_Offset) ? (w_Pop - io_Bus.i_Fine_Offset) : '0;
`else
  assign w_Fine = w_Pop;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State   <= S_IDLE;
      r_Count   <= '0;
      r_Busy    <= 1'b0;
      r_Valid   <= 1'b0;
      r_Coarse  <= '0;
      r_Fine    <= '0;
      r_Timeout <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (io_Bus.i_Arm) begin
            r_State <= S_ARMED;
            r_Busy  <= 1'b1;
            r_Count <= '0;
          end
        end
        S_ARMED: begin
          // A hit on the final count takes priority over the timeout.
          if (io_Bus.i_Hit) begin
            r_Coarse <= r_Count;
            r_State  <= S_CAPTURE;
          end else if (r_Count == c_LAST) begin
            r_Coarse  <= c_LAST;
            r_Fine    <= '0;
            r_Timeout <= 1'b1;
            r_Valid   <= 1'b1;
            r_State   <= S_RESULT;
          end else begin
            r_Count <= r_Count + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_Fine    <= w_Fine;
          r_Timeout <= 1'b0;
          r_Valid   <= 1'b1;
          r_State   <= S_RESULT;
        end
        S_RESULT: begin
          if (io_Bus.i_Ready) begin
            r_Valid <= 1'b0;
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end
        end
        default: begin
          r_State <= S_IDLE;
          r_Busy  <= 1'b0;
          r_Valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_Bus.o_Busy    = r_Busy;
  assign io_Bus.o_Valid   = r_Valid;
  assign io_Bus.o_Coarse  = r_Coarse;
  assign io_Bus.o_Fine    = r_Fine;
  assign io_Bus.o_Timeout = r_Timeout;

endmodule
`default_nettype wire

// File: tb/tb_tdc_measure_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tdc_measure_sequencer
// Description : Transaction-level model of the TDC sequencer with randomized
//               and directed measurements; honours TDC_FINE_OFFSET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_measure_sequencer;
  import tdc_ctrl_pkg::*;

  localparam int COARSE_W = c_COARSE_W;
  localparam int TO       = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdc_measure_sequencer_if #(.COARSE_W(COARSE_W)) bus ();

  tdc_measure_sequencer #(.COARSE_W(COARSE_W), .TIMEOUT_CYC(TO)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .io_Bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          offset   = 0;
  bit          chk_en   = 1'b0;
  bit          exp_busy;
  bit          exp_valid;
  tdc_result_t exp_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [35:0] rand36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  // Expected record of one measurement from the arm-to-result rules.
  function automatic tdc_result_t model(input int hit_k, input logic [35:0] seq);
    tdc_result_t m;
    int pc;
    pc = $countones(seq);
    if (hit_k >= 0 && hit_k < TO) begin
      m.timeout = 1'b0;
      m.coarse  = COARSE_W'(hit_k);
      m.fine    = c_FINE_W'((pc > offset) ? pc - offset : 0);
    end else begin
      m.timeout = 1'b1;
      m.coarse  = COARSE_W'(TO - 1);
      m.fine    = '0;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.o_Busy), 64'(exp_busy));
      check("valid", 64'(bus.o_Valid), 64'(exp_valid));
      if (exp_valid) begin
        check("coarse", 64'(bus.o_Coarse), 64'(exp_res.coarse));
        check("fine", 64'(bus.o_Fine), 64'(exp_res.fine));
        check("timeout", 64'(bus.o_Timeout), 64'(exp_res.timeout));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns in an IDLE cycle.
  task automatic txn(input int hit_k, input logic [35:0] seq, input int wait_n,
                     input int lit_c, input int lit_f, input int lit_t);
    tdc_result_t r;
    int last_k;
    bit is_hit;
    r      = model(hit_k, seq);
    is_hit = (hit_k >= 0 && hit_k < TO);
    last_k = is_hit ? hit_k : TO - 1;
    bus.i_Arm = 1'b1;
    step();
    exp_busy  = 1'b1;
    exp_valid = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      bus.i_Arm      = 1'($urandom());
      bus.i_Hit      = (k == hit_k);
      bus.i_Sequence = (k == hit_k) ? seq : rand36();
      step();
    end
    if (is_hit) begin
      bus.i_Hit      = 1'($urandom());
      bus.i_Arm      = 1'($urandom());
      bus.i_Sequence = rand36();
      step();
    end
    exp_res   = r;
    exp_valid = 1'b1;
    if (lit_c >= 0) check("lit_coarse", 64'(bus.o_Coarse), 64'(lit_c));
    if (lit_f >= 0) check("lit_fine", 64'(bus.o_Fine), 64'(lit_f));
    if (lit_t >= 0) check("lit_timeout", 64'(bus.o_Timeout), 64'(lit_t));
    for (int w = 0; w < wait_n; w++) begin
      bus.i_Ready    = 1'b0;
      bus.i_Arm      = 1'($urandom());
      bus.i_Hit      = 1'($urandom());
      bus.i_Sequence = rand36();
      step();
    end
    bus.i_Ready = 1'b1;
    bus.i_Arm   = 1'($urandom());
    step();
    bus.i_Ready = 1'b0;
    bus.i_Arm   = 1'b0;
    bus.i_Hit   = 1'($urandom());
    exp_busy    = 1'b0;
    exp_valid   = 1'b0;
    step();
    bus.i_Hit = 1'b0;
  endtask

  task automatic reset_in(input bit in_capture);
    bus.i_Arm = 1'b1;
    step();
    bus.i_Arm = 1'b0;
    exp_busy  = 1'b1;
    exp_valid = 1'b0;
    step();
    step();
    if (in_capture) begin
      bus.i_Hit      = 1'b1;
      bus.i_Sequence = 36'hFFFFFFFFF;
      step();
      bus.i_Hit = 1'b0;
    end
    rst = 1'b1;
    step();
    rst      = 1'b0;
    exp_busy = 1'b0;
    check("rst_coarse", 64'(bus.o_Coarse), 64'd0);
    check("rst_fine", 64'(bus.o_Fine), 64'd0);
    check("rst_timeout", 64'(bus.o_Timeout), 64'd0);
    repeat (4) step();
  endtask

  initial begin
    int f8, f20, f36, f18;
    rst            = 1'b1;
    bus.i_Arm      = 1'b0;
    bus.i_Hit      = 1'b0;
    bus.i_Ready    = 1'b0;
    bus.i_Sequence = '0;
`ifdef TDC_FINE_OFFSET_EN
    offset            = 10;
    bus.i_Fine_Offset = 6'd10;
    f8 = 0; f20 = 10; f36 = 26; f18 = 8;
`else
    f8 = 8; f20 = 20; f36 = 36; f18 = 18;
`endif
    repeat (3) step();
    rst = 1'b0;
    check("reset_busy", 64'(bus.o_Busy), 64'd0);
    check("reset_valid", 64'(bus.o_Valid), 64'd0);
    check("reset_coarse", 64'(bus.o_Coarse), 64'd0);
    check("reset_fine", 64'(bus.o_Fine), 64'd0);
    check("reset_timeout", 64'(bus.o_Timeout), 64'd0);
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    chk_en    = 1'b1;
    step();

    txn(3, 36'h0000000FF, 0, 3, f8, 0);
    txn(1, 36'hFFFFFFFFF, 1, 1, f36, 0);
    txn(0, 36'h000000000, 0, 0, 0, 0);
    txn(6, 36'hA5A5A5A5A, 2, 6, f18, 0);
    txn(4, 36'h0000FFFFF, 0, 4, f20, 0);
    txn(-1, 36'h0, 1, 15, 0, 1);
    txn(15, 36'h0000000FF, 0, 15, f8, 0);
    txn(2, 36'h123456789, 5, 2, -1, 0);
    reset_in(1'b0);
    reset_in(1'b1);

    for (int n = 0; n < 40; n++) begin
      int hk;
      logic [35:0] sq;
      hk = $urandom_range(0, TO + 3);
      if (hk >= TO) hk = -1;
      sq = ($urandom_range(0, 1) == 0) ? rand36() : ((36'h1 << $urandom_range(0, 35)) - 36'h1);
      txn(hk, sq, $urandom_range(0, 3), -1, -1, -1);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
